// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one shared memory bus.
// The grant is registered; the payload passes straight through from the owner.
module mem_arbiter #(
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic        i_rw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_dtw,
    output logic        i_ready,
    output logic [31:0] i_dtr,
    input  logic        d_valid,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dtw,
    output logic        d_ready,
    output logic [31:0] d_dtr,
    output logic        m_valid,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    input  logic        m_ready,
    input  logic [31:0] m_dtr,
    output logic [1:0]  gnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;  // 1 = data port was served last

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_valid && d_valid)
                    state_d = (RR == 0 || !last_q) ? GNT_D : GNT_I;
                else if (i_valid)
                    state_d = GNT_I;
                else if (d_valid)
                    state_d = GNT_D;
                if (state_d == GNT_D)
                    last_d = 1'b1;
                else if (state_d == GNT_I)
                    last_d = 1'b0;
            end
            // A dropped valid releases the grant just like a completion does.
            GNT_I: if (!i_valid || m_ready) state_d = IDLE;
            GNT_D: if (!d_valid || m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_rw    = 1'b0;
        m_addr  = '0;
        m_dtw   = '0;
        i_ready = 1'b0;
        i_dtr   = '0;
        d_ready = 1'b0;
        d_dtr   = '0;
        case (state_q)
            GNT_I: begin
                m_valid = i_valid;
                m_rw    = i_rw;
                m_addr  = i_addr;
                m_dtw   = i_dtw;
                i_ready = m_ready && i_valid;
                i_dtr   = m_dtr;
            end
            GNT_D: begin
                m_valid = d_valid;
                m_rw    = d_rw;
                m_addr  = d_addr;
                m_dtw   = d_dtw;
                d_ready = m_ready && d_valid;
                d_dtr   = m_dtr;
            end
            default: ;
        endcase
    end

    assign gnt  = {state_q == GNT_D, state_q == GNT_I};
    assign busy = |gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model, driving a fixed-priority and a round-robin arbiter in parallel.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iv = 0, irw = 0, dv = 0, drw = 0, mr = 0;
    logic [31:0] ia = 0, idtw = 0, da = 0, ddtw = 0, mdtr = 0;

    logic [1:0]  gnt_w  [2];
    logic        busy_w [2], mv_w [2], mrw_w [2], ir_w [2], dr_w [2];
    logic [31:0] ma_w   [2], mdtw_w [2], idtr_w [2], ddtr_w [2];

    int checks = 0;
    int failures = 0;

    // Model: owner 0 = nobody, 1 = fetch port, 2 = data port. Index 0 = fixed, 1 = RR.
    int own   [2];
    bit lastd [2];

    always #5 clk = ~clk;

    mem_arbiter #(.RR(0)) u_fp (
        .clk(clk), .reset(reset),
        .i_valid(iv), .i_rw(irw), .i_addr(ia), .i_dtw(idtw), .i_ready(ir_w[0]), .i_dtr(idtr_w[0]),
        .d_valid(dv), .d_rw(drw), .d_addr(da), .d_dtw(ddtw), .d_ready(dr_w[0]), .d_dtr(ddtr_w[0]),
        .m_valid(mv_w[0]), .m_rw(mrw_w[0]), .m_addr(ma_w[0]), .m_dtw(mdtw_w[0]),
        .m_ready(mr), .m_dtr(mdtr), .gnt(gnt_w[0]), .busy(busy_w[0])
    );

    mem_arbiter #(.RR(1)) u_rr (
        .clk(clk), .reset(reset),
        .i_valid(iv), .i_rw(irw), .i_addr(ia), .i_dtw(idtw), .i_ready(ir_w[1]), .i_dtr(idtr_w[1]),
        .d_valid(dv), .d_rw(drw), .d_addr(da), .d_dtw(ddtw), .d_ready(dr_w[1]), .d_dtr(ddtr_w[1]),
        .m_valid(mv_w[1]), .m_rw(mrw_w[1]), .m_addr(ma_w[1]), .m_dtw(mdtw_w[1]),
        .m_ready(mr), .m_dtr(mdtr), .gnt(gnt_w[1]), .busy(busy_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after inputs are driven at a falling edge: compares every
    // output of both instances to the model, then advances the model over
    // the next rising edge.
    task automatic cyc();
        #1;
        if (reset) begin
            own[0] = 0; own[1] = 0; lastd[0] = 0; lastd[1] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            bit ei = (own[k] == 1);
            bit ed = (own[k] == 2);
            logic        ev  = ei ? iv : (ed ? dv : 1'b0);
            logic        erw = ei ? irw : (ed ? drw : 1'b0);
            logic [31:0] ea  = ei ? ia : (ed ? da : 32'h0);
            logic [31:0] ew  = ei ? idtw : (ed ? ddtw : 32'h0);
            chk($sformatf("u%0d.gnt", k),     {30'h0, gnt_w[k]}, {30'h0, ed, ei});
            chk($sformatf("u%0d.busy", k),    {31'h0, busy_w[k]}, {31'h0, ei | ed});
            chk($sformatf("u%0d.m_valid", k), {31'h0, mv_w[k]}, {31'h0, ev});
            chk($sformatf("u%0d.m_rw", k),    {31'h0, mrw_w[k]}, {31'h0, erw});
            chk($sformatf("u%0d.m_addr", k),  ma_w[k], ea);
            chk($sformatf("u%0d.m_dtw", k),   mdtw_w[k], ew);
            chk($sformatf("u%0d.i_ready", k), {31'h0, ir_w[k]}, {31'h0, ei & ev & mr});
            chk($sformatf("u%0d.i_dtr", k),   idtr_w[k], ei ? mdtr : 32'h0);
            chk($sformatf("u%0d.d_ready", k), {31'h0, dr_w[k]}, {31'h0, ed & ev & mr});
            chk($sformatf("u%0d.d_dtr", k),   ddtr_w[k], ed ? mdtr : 32'h0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                own[k] = 0; lastd[k] = 0;
            end else if (own[k] == 0) begin
                if (iv || dv) begin
                    bit pick_d;
                    if (iv && dv) pick_d = (k == 0) ? 1'b1 : !lastd[k];
                    else          pick_d = dv;
                    own[k]   = pick_d ? 2 : 1;
                    lastd[k] = pick_d;
                end
            end else if (own[k] == 1) begin
                if (!iv || mr) own[k] = 0;
            end else begin
                if (!dv || mr) own[k] = 0;
            end
        end
    endtask

    task automatic clear_in();
        iv = 0; irw = 0; ia = 0; idtw = 0;
        dv = 0; drw = 0; da = 0; ddtw = 0;
        mr = 0; mdtr = 0;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1; clear_in();
        cyc();
        @(negedge clk);
        reset = 0;
    endtask

    logic [1:0] seq_rr [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [1:0] seq_fp [8] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    int npulse, nir;

    initial begin
        own[0] = 0; own[1] = 0; lastd[0] = 0; lastd[1] = 0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_gnt", {30'h0, gnt_w[1]}, 32'h0);
        chk("rst_busy", {31'h0, busy_w[1]}, 32'h0);
        chk("rst_mvalid", {31'h0, mv_w[0]}, 32'h0);
        cyc();
        pulse_reset();

        // Single fetch read, ready tied to valid
        iv = 1; ia = 32'h100; mdtr = 32'h1234_5678; mr = 0;
        #1 chk("s30_c0_mvalid", {31'h0, mv_w[1]}, 32'h0);
        cyc();
        @(negedge clk); mr = 1;
        #1;
        chk("s30_c1_mvalid", {31'h0, mv_w[1]}, 32'h1);
        chk("s30_c1_addr", ma_w[1], 32'h100);
        chk("s30_c1_iready", {31'h0, ir_w[1]}, 32'h1);
        chk("s30_c1_idtr", idtr_w[1], 32'h1234_5678);
        cyc();
        @(negedge clk); mr = 0;
        #1 chk("s30_c2_gnt", {30'h0, gnt_w[1]}, 32'h0);
        cyc();

        // Both ports requesting continuously
        pulse_reset();
        iv = 1; dv = 1; mr = 1; ia = 32'hA0; da = 32'hB0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("s31_gnt%0d", c), {30'h0, gnt_w[1]}, {30'h0, seq_rr[c]});
            chk($sformatf("s32_gnt%0d", c), {30'h0, gnt_w[0]}, {30'h0, seq_fp[c]});
            chk($sformatf("s32_iready%0d", c), {31'h0, ir_w[0]}, 32'h0);
            cyc();
        end

        // Data write with registered downstream ready
        pulse_reset();
        npulse = 0; nir = 0;
        dv = 1; drw = 1; da = 32'h200; ddtw = 32'hDEAD_BEEF; mr = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            mr = (c == 2);
            if (c == 3) dv = 0;
            #1;
            if (c == 1 || c == 2) chk($sformatf("s33_dtw%0d", c), mdtw_w[1], 32'hDEAD_BEEF);
            npulse += int'(dr_w[1]);
            nir    += int'(ir_w[1]);
            cyc();
        end
        chk("s33_dready_pulses", npulse, 1);
        chk("s33_iready_pulses", nir, 0);

        // Reset in the middle of a fetch grant
        pulse_reset();
        iv = 1; ia = 32'h300; mr = 0;
        cyc();
        @(negedge clk);
        #1 chk("s34_gnt_before", {30'h0, gnt_w[1]}, 32'h1);
        cyc();
        @(negedge clk); reset = 1;
        #1;
        chk("s34_async_gnt", {30'h0, gnt_w[1]}, 32'h0);
        chk("s34_async_mvalid", {31'h0, mv_w[1]}, 32'h0);
        chk("s34_async_iready", {31'h0, ir_w[1]}, 32'h0);
        cyc();
        @(negedge clk); reset = 0;
        #1 chk("s34_release_idle", {30'h0, gnt_w[1]}, 32'h0);
        cyc();
        @(negedge clk);
        #1 chk("s34_regrant", {30'h0, gnt_w[1]}, 32'h1);
        cyc();

        // Owner drops valid before completion
        pulse_reset();
        iv = 1; dv = 1; mr = 0;
        cyc();
        @(negedge clk);
        #1 chk("s35_gnt_d", {30'h0, gnt_w[1]}, 32'h2);
        cyc();
        @(negedge clk); dv = 0;
        #1 chk("s35_no_dready", {31'h0, dr_w[1]}, 32'h0);
        cyc();
        @(negedge clk);
        #1 chk("s35_idle", {30'h0, gnt_w[1]}, 32'h0);
        cyc();
        @(negedge clk);
        #1;
        chk("s35_gnt_i_rr", {30'h0, gnt_w[1]}, 32'h1);
        chk("s35_gnt_i_fp", {30'h0, gnt_w[0]}, 32'h1);
        cyc();

        // Randomized traffic, including stray resets and dropped valids
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 59) == 0);
            iv    = ($urandom_range(0, 3) != 0);
            dv    = ($urandom_range(0, 2) != 0);
            irw   = $urandom_range(0, 1);
            drw   = $urandom_range(0, 1);
            ia    = $urandom;
            da    = $urandom;
            idtw  = $urandom;
            ddtw  = $urandom;
            mdtr  = $urandom;
            mr    = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
